// File: rtl/nios_system_avst_arb_pkg.sv
// Shared types and width helpers for the packet-aware Avalon-ST arbiter.
package nios_system_avst_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_IN  = 4;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_ERR_W   = 6;
  localparam int unsigned DEF_EMPTY_W = 2;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  localparam int unsigned DEF_CHANNEL_W = clog2(DEF_NUM_IN);

endpackage

// File: rtl/nios_system_avst_rr_picker.sv
// Combinational round-robin picker: first requester after ptr, wrapping mod NUM_IN.
module nios_system_avst_rr_picker
  import nios_system_avst_arb_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int CHANNEL_W = 2
) (
  input  logic [NUM_IN-1:0]    req,
  input  logic [CHANNEL_W-1:0] ptr,
  output logic [CHANNEL_W-1:0] grant,
  output logic                 any_req
);

  // Walk the search order backwards so the last hit is the highest-priority one.
  always_comb begin
    int idx;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = NUM_IN; i >= 1; i--) begin
      idx = (int'(ptr) + i) % NUM_IN;
      if (req[idx]) begin
        grant   = CHANNEL_W'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios_system_avalon_st_packet_arbiter.sv
// Packet-locked N:1 Avalon-ST arbiter with one registered output stage.
// Define AVST_ARB_FIXED_PRIO_EN to give source 0 absolute priority in IDLE.
module nios_system_avalon_st_packet_arbiter
  import nios_system_avst_arb_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 32,
  parameter int ERR_W     = 6,
  parameter int EMPTY_W   = 2,
  parameter int CHANNEL_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [NUM_IN*DATA_W-1:0]    in_data,
  input  logic [NUM_IN*ERR_W-1:0]     in_error,
  input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
  input  logic [NUM_IN-1:0]           in_startofpacket,
  input  logic [NUM_IN-1:0]           in_endofpacket,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [CHANNEL_W-1:0]        out_channel,
  output logic [ERR_W-1:0]            out_error,
  output logic [EMPTY_W-1:0]          out_empty,
  output logic                        out_startofpacket,
  output logic                        out_endofpacket
);

  // Handshake: a beat moves on any edge where valid & ready are both high;
  // valid never waits on ready, and out_* stay frozen while out_valid & ~out_ready.

  arb_state_e             state_q, state_d;
  logic [CHANNEL_W-1:0]   grant_q, grant_d;
  logic [CHANNEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [CHANNEL_W-1:0]   out_channel_q, out_channel_d;
  logic [ERR_W-1:0]       out_error_q, out_error_d;
  logic [EMPTY_W-1:0]     out_empty_q, out_empty_d;
  logic                   out_sop_q, out_sop_d;
  logic                   out_eop_q, out_eop_d;

  logic [NUM_IN-1:0]      rr_req;
  logic [CHANNEL_W-1:0]   rr_grant;
  logic                   rr_any;
  logic [CHANNEL_W-1:0]   pick_grant;
  logic                   pick_any;
  logic                   accept;

`ifdef AVST_ARB_FIXED_PRIO_EN
  assign rr_req     = {in_valid[NUM_IN-1:1], 1'b0};
  assign pick_grant = in_valid[0] ? '0 : rr_grant;
  assign pick_any   = in_valid[0] | rr_any;
`else
  assign rr_req     = in_valid;
  assign pick_grant = rr_grant;
  assign pick_any   = rr_any;
`endif

  nios_system_avst_rr_picker #(
    .NUM_IN    (NUM_IN),
    .CHANNEL_W (CHANNEL_W)
  ) u_picker (
    .req     (rr_req),
    .ptr     (rr_ptr_q),
    .grant   (rr_grant),
    .any_req (rr_any)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_error_d   = out_error_q;
    out_empty_d   = out_empty_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    in_ready      = '0;
    accept        = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          state_d = LOCK;
        end
      end
      LOCK: begin
        in_ready[grant_q] = ~out_valid_q | out_ready;
        accept            = in_valid[grant_q] & in_ready[grant_q];
        if (accept) begin
          out_valid_d   = 1'b1;
          out_data_d    = in_data[int'(grant_q)*DATA_W +: DATA_W];
          out_channel_d = grant_q;
          out_error_d   = in_error[int'(grant_q)*ERR_W +: ERR_W];
          out_empty_d   = in_empty[int'(grant_q)*EMPTY_W +: EMPTY_W];
          out_sop_d     = in_startofpacket[grant_q];
          out_eop_d     = in_endofpacket[grant_q];
          if (in_endofpacket[grant_q]) begin
`ifdef AVST_ARB_FIXED_PRIO_EN
            if (grant_q != '0) rr_ptr_d = grant_q;
`else
            rr_ptr_d = grant_q;
`endif
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      rr_ptr_q      <= CHANNEL_W'(NUM_IN - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_error_q   <= '0;
      out_empty_q   <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_ptr_q      <= rr_ptr_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      out_error_q   <= out_error_d;
      out_empty_q   <= out_empty_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_channel       = out_channel_q;
  assign out_error         = out_error_q;
  assign out_empty         = out_empty_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;

endmodule
